// File: rtl/hbm_bender_pkg.sv
// Shared types for the HBM maintenance scheduler: maintenance kinds and FSM states.
package hbm_bender_pkg;
  localparam int MAINT_TYPE_W = 2;

  typedef enum logic [MAINT_TYPE_W-1:0] {
    MT_REF = 2'd0,
    MT_ZQ  = 2'd1,
    MT_RD  = 2'd2
  } maint_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ISSUE = 2'd2
  } sched_state_e;
endpackage

// File: rtl/hbm_maint_timer.sv
// Programmable periodic timer: one-cycle fire every `interval` cycles, 0 disables.
module hbm_maint_timer
  import hbm_bender_pkg::*;
#(
  parameter int CFG_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_we,
  input  logic [CFG_W-1:0] i_data,
  output logic             o_fire
);
  localparam logic [CFG_W-1:0] ONE = CFG_W'(1);

  logic [CFG_W-1:0] r_ival;
  logic [CFG_W-1:0] r_cnt;
  logic             w_live;

  assign w_live = i_en && (r_ival != '0);
  assign o_fire = w_live && (r_cnt == '0);

  // A frozen or disabled timer sits at its reload value so it restarts a full period.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ival <= '0;
      r_cnt  <= '0;
    end else if (i_we) begin
      r_ival <= i_data;
      r_cnt  <= i_data - ONE;
    end else if (!w_live || o_fire) begin
      r_cnt  <= r_ival - ONE;
    end else begin
      r_cnt  <= r_cnt - ONE;
    end
  end
endmodule

// File: rtl/hbm_maint_scheduler.sv
// Maintenance scheduler: REF debt, ZQ/RD pending flags, priority pick and issue FSM
// that slots maintenance between instruction sequences.
module hbm_maint_scheduler
  import hbm_bender_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int MAX_DEBT    = 8,
  parameter int URGENT_DEBT = 4,
  parameter int CFG_W       = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_sched_en,
  input  logic                      i_cfg_we,
  input  logic [1:0]                i_cfg_sel,
  input  logic [CFG_W-1:0]          i_cfg_data,
  input  logic                      i_iseq_busy,
  output logic                      o_iseq_hold,
  output logic                      o_maint_req,
  output logic [MAINT_TYPE_W-1:0]   o_maint_type,
  output logic [$clog2(NUM_CH)-1:0] o_maint_ch,
  input  logic                      i_maint_ack,
  output logic [3:0]                o_ref_debt,
  output logic                      o_debt_ovf
);
  localparam int         CH_W  = $clog2(NUM_CH);
  localparam logic [3:0] MAX_D = 4'(MAX_DEBT);
  localparam logic [3:0] URG_D = 4'(URGENT_DEBT);

  sched_state_e      r_state, w_nxt;
  maint_type_e       r_type, w_pick;
  logic [CH_W-1:0]   r_ptr;
  logic [3:0]        r_debt;
  logic              r_ovf, r_zq_pend, r_rd_pend;
  logic [2:0]        w_fire, w_we;
  logic              w_ack_ok, w_ref_ack, w_zq_ack, w_rd_ack, w_any, w_urgent;

  for (genvar g = 0; g < 3; g++) begin : g_tmr
    assign w_we[g] = i_cfg_we && (i_cfg_sel == 2'(g));
    hbm_maint_timer #(.CFG_W(CFG_W)) u_tmr (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_en   (i_sched_en),
      .i_we   (w_we[g]),
      .i_data (i_cfg_data),
      .o_fire (w_fire[g])
    );
  end

  assign w_ack_ok  = i_maint_ack && (r_state == ST_ISSUE);
  assign w_ref_ack = w_ack_ok && (r_type == MT_REF);
  assign w_zq_ack  = w_ack_ok && (r_type == MT_ZQ);
  assign w_rd_ack  = w_ack_ok && (r_type == MT_RD);

  assign w_any    = (r_debt != '0) || r_zq_pend || r_rd_pend;
  assign w_urgent = (r_debt >= URG_D) || r_zq_pend;
  assign w_pick   = (r_debt != '0) ? MT_REF : (r_zq_pend ? MT_ZQ : MT_RD);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_sched_en && w_any) begin
          if (!i_iseq_busy)  w_nxt = ST_ISSUE;
          else if (w_urgent) w_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: if (!i_iseq_busy) w_nxt = ST_ISSUE;
      ST_ISSUE: if (i_maint_ack)  w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_type    <= MT_REF;
      r_ptr     <= '0;
      r_debt    <= '0;
      r_ovf     <= 1'b0;
      r_zq_pend <= 1'b0;
      r_rd_pend <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == ST_IDLE && w_nxt != ST_IDLE) r_type <= w_pick;
      if (w_ref_ack) r_ptr <= r_ptr + CH_W'(1);
      // A fire absorbed by a same-cycle ack is not an overflow.
      if (w_fire[0] && !w_ref_ack) begin
        if (r_debt == MAX_D) r_ovf  <= 1'b1;
        else                 r_debt <= r_debt + 4'd1;
      end else if (w_ref_ack && !w_fire[0]) begin
        r_debt <= r_debt - 4'd1;
      end
      r_zq_pend <= i_sched_en && (w_fire[1] || (r_zq_pend && !w_zq_ack));
      r_rd_pend <= i_sched_en && (w_fire[2] || (r_rd_pend && !w_rd_ack));
    end
  end

  assign o_iseq_hold  = (r_state != ST_IDLE);
  assign o_maint_req  = (r_state == ST_ISSUE);
  assign o_maint_type = r_type;
  assign o_maint_ch   = (r_type == MT_REF) ? r_ptr : '0;
  assign o_ref_debt   = r_debt;
  assign o_debt_ovf   = r_ovf;
endmodule

// File: tb/tb_hbm_maint_scheduler.sv
// Bench for hbm_maint_scheduler: directed scenarios plus random traffic against a
// deadline-based behavioural model, compared on every falling edge.
module tb_hbm_maint_scheduler;
  localparam int NCH = 8, MAXD = 8, URG = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, en = 1'b1, we = 1'b0, busy = 1'b0, ack = 1'b0;
  logic [1:0]  sel = '0;
  logic [31:0] data = '0;
  logic        o_iseq_hold, o_maint_req, o_debt_ovf;
  logic [1:0]  o_maint_type;
  logic [2:0]  o_maint_ch;
  logic [3:0]  o_ref_debt;

  hbm_maint_scheduler #(.NUM_CH(NCH), .MAX_DEBT(MAXD), .URGENT_DEBT(URG), .CFG_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sched_en(en), .i_cfg_we(we), .i_cfg_sel(sel),
    .i_cfg_data(data), .i_iseq_busy(busy), .o_iseq_hold(o_iseq_hold),
    .o_maint_req(o_maint_req), .o_maint_type(o_maint_type), .o_maint_ch(o_maint_ch),
    .i_maint_ack(ack), .o_ref_debt(o_ref_debt), .o_debt_ovf(o_debt_ovf));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_on = 1'b0;

  // Model: each timer is an interval plus the absolute cycle of its next fire.
  int cyc = 0;
  int ival[3], due[3];
  bit m_req, m_hold, m_zq, m_rd, m_ovf;
  int m_type, m_ptr, m_debt;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin ival[k] = 0; due[k] = 0; end
    m_req = 0; m_hold = 0; m_zq = 0; m_rd = 0; m_ovf = 0;
    m_type = 0; m_ptr = 0; m_debt = 0;
  endtask

  task automatic model_step();
    bit f[3];
    bit ack_ok, refack, zqack, rdack, zq0, rd0;
    int d0, pick;
    if (!rst_n) begin model_reset(); cyc++; return; end
    for (int k = 0; k < 3; k++) f[k] = en && ival[k] != 0 && due[k] == cyc;
    ack_ok = m_req && ack;
    refack = ack_ok && m_type == 0;
    zqack  = ack_ok && m_type == 1;
    rdack  = ack_ok && m_type == 2;
    d0 = m_debt; zq0 = m_zq; rd0 = m_rd;
    // scheduler decision uses state from before this edge
    if (m_req) begin
      if (ack) begin m_req = 0; m_hold = 0; if (m_type == 0) m_ptr = (m_ptr + 1) % NCH; end
    end else if (m_hold) begin
      if (!busy) m_req = 1;
    end else if (en && (d0 > 0 || zq0 || rd0)) begin
      pick = (d0 > 0) ? 0 : (zq0 ? 1 : 2);
      if (!busy) begin m_req = 1; m_hold = 1; m_type = pick; end
      else if (d0 >= URG || zq0) begin m_hold = 1; m_type = pick; end
    end
    if (f[0] && !refack) begin
      if (m_debt == MAXD) m_ovf = 1; else m_debt++;
    end else if (refack && !f[0]) m_debt--;
    m_zq = en && (f[1] || (zq0 && !zqack));
    m_rd = en && (f[2] || (rd0 && !rdack));
    for (int k = 0; k < 3; k++) begin
      if (we && sel == 2'(k)) begin ival[k] = int'(data); due[k] = cyc + int'(data); end
      else if (!en || ival[k] == 0 || f[k]) due[k] = cyc + ival[k];
    end
    cyc++;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("req",  int'(o_maint_req), int'(m_req));
      check("hold", int'(o_iseq_hold), int'(m_hold));
      check("debt", int'(o_ref_debt),  m_debt);
      check("ovf",  int'(o_debt_ovf),  int'(m_ovf));
      if (m_req) begin
        check("type", int'(o_maint_type), m_type);
        check("ch",   int'(o_maint_ch),   (m_type == 0) ? m_ptr : 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1; model_step();
  endtask

  task automatic cfg(input int s, input int d);
    we = 1'b1; sel = 2'(s); data = 32'(d); tick(); we = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; we = 1'b0; ack = 1'b0; busy = 1'b0; en = 1'b1;
    tick(); rst_n = 1'b1;
  endtask

  task automatic wait_req(input string nm, input int lim, output int n);
    n = 0;
    while (!o_maint_req && n < lim) begin tick(); n++; end
    total++;
    if (!o_maint_req) begin
      bad++;
      $display("FAIL %s: maint_req got 0 expected 1 within %0d cycles", nm, lim);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nreq;
    bit early;
    model_reset();
    repeat (3) tick();
    chk_on = 1'b1;
    rst_n = 1'b1;
    check("rst_req", int'(o_maint_req), 0);
    check("rst_hold", int'(o_iseq_hold), 0);
    check("rst_debt", int'(o_ref_debt), 0);

    // REF latency and channel round-robin
    cfg(0, 100);
    wait_req("t1_first", 200, n);
    check("t1_latency", n, 101);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) wait_req("t1_next", 150, n);
      check("t1_ch", int'(o_maint_ch), k % 8);
      check("t1_type", int'(o_maint_type), 0);
      pulse_ack();
    end

    // debt builds under busy; hold only once urgent
    do_reset(); busy = 1'b1; cfg(0, 10);
    n = 0; early = 0;
    while (o_ref_debt < 4 && n < 100) begin if (o_iseq_hold) early = 1; tick(); n++; end
    check("t2_debt4", int'(o_ref_debt), 4);
    check("t2_no_early_hold", int'(early), 0);
    tick();
    check("t2_hold", int'(o_iseq_hold), 1);
    check("t2_no_req", int'(o_maint_req), 0);
    busy = 1'b0; tick();
    check("t2_req", int'(o_maint_req), 1);
    pulse_ack();
    check("t2_debt3", int'(o_ref_debt), 3);

    // saturation and sticky overflow
    do_reset(); busy = 1'b1; cfg(0, 5);
    repeat (60) tick();
    check("t3_debt_sat", int'(o_ref_debt), 8);
    check("t3_ovf", int'(o_debt_ovf), 1);
    repeat (10) tick();
    check("t3_ovf_sticky", int'(o_debt_ovf), 1);
    do_reset();
    check("t3_ovf_cleared", int'(o_debt_ovf), 0);

    // ZQ beats RD on a shared fire; RD refires are absorbed
    do_reset(); cfg(1, 21); cfg(2, 20);
    wait_req("t4_zq", 40, n);
    check("t4_zq_type", int'(o_maint_type), 1);
    check("t4_zq_ch", int'(o_maint_ch), 0);
    pulse_ack();
    wait_req("t4_rd", 10, n);
    check("t4_rd_type", int'(o_maint_type), 2);
    check("t4_rd_ch", int'(o_maint_ch), 0);
    pulse_ack();
    cfg(1, 0); cfg(2, 0);
    busy = 1'b1; cfg(2, 8);
    repeat (20) tick();
    check("t4_rd_no_hold", int'(o_iseq_hold), 0);
    cfg(2, 0); busy = 1'b0;
    nreq = 0;
    for (int i = 0; i < 30; i++) begin
      if (o_maint_req) begin nreq++; ack = 1'b1; end else ack = 1'b0;
      tick();
    end
    ack = 1'b0;
    check("t4_rd_absorbed", nreq, 1);

    // fire coincident with ack; acks while idle ignored
    do_reset(); busy = 1'b1; cfg(0, 10);
    n = 0;
    while (o_ref_debt < 3 && n < 100) begin tick(); n++; end
    busy = 1'b0;
    wait_req("t5_req", 10, n);
    n = 0;
    while (due[0] != cyc && n < 30) begin tick(); n++; end
    check("t5_aligned", int'(due[0] == cyc), 1);
    pulse_ack();
    check("t5_debt_same", int'(o_ref_debt), 3);
    busy = 1'b1; cfg(0, 0);
    ack = 1'b1; repeat (3) tick(); ack = 1'b0;
    check("t5_idle_ack_debt", int'(o_ref_debt), 3);
    check("t5_idle_no_req", int'(o_maint_req), 0);

    // reset during ISSUE clears everything including intervals
    do_reset(); cfg(0, 10);
    wait_req("t6_req", 20, n);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("t6_req", int'(o_maint_req), 0);
    check("t6_hold", int'(o_iseq_hold), 0);
    check("t6_debt", int'(o_ref_debt), 0);
    check("t6_ch", int'(o_maint_ch), 0);
    check("t6_type", int'(o_maint_type), 0);
    nreq = 0;
    for (int i = 0; i < 50; i++) begin if (o_maint_req) nreq++; tick(); end
    check("t6_no_req_after_rst", nreq, 0);
    cfg(0, 10);
    wait_req("t6_reprogrammed", 20, n);
    pulse_ack();

    // random traffic against the model
    cfg(0, 12); cfg(1, 37); cfg(2, 23);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) busy = !busy;
      ack = o_maint_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      we = ($urandom_range(0, 49) == 0);
      sel = 2'($urandom_range(0, 3));
      data = 32'($urandom_range(0, 30));
      if (en) en = ($urandom_range(0, 299) != 0);
      else    en = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 1999) != 0);
      tick();
    end
    we = 1'b0; ack = 1'b0; rst_n = 1'b1;
    tick(); tick();
    chk_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
